fp_round_stage: RTL and testbench

Parametrised, pipelined rounding and result-select stage for the floating-point adder datapath, placed between the normaliser and the result register file. It takes a normalised mantissa with guard, round and sticky bits. It selects either the truncated or the round-to-nearest-even result under a per-operation mode bit, renormalises on rounding carry-out and saturates exponent overflow to infinity. Output is registered and fully handshaked, with a 2-entry skid buffer so back-pressure never drops or duplicates a result.

---
 rtl/fp_add_pkg.sv | 24 ++
 rtl/fp_round_core.sv | 57 +++++
 rtl/fp_round_stage.sv | 118 +++++++++++
 tb/tb_fp_round_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared constants and types for the floating-point adder datapath:
// default widths, round-mode encoding, skid-buffer state encoding and exponent saturation helper.
package fp_add_pkg;

    localparam int MANT_W_DEF = 8;
    localparam int EXP_W_DEF  = 8;

    typedef enum logic {
        ROUND_TRUNC = 1'b0,
        ROUND_RNE   = 1'b1
    } round_mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // All-ones biased exponent (infinity / NaN code) for a given exponent width, w < 64.
    function automatic logic [63:0] exp_all_ones(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/fp_round_core.sv
// Combinational round-to-nearest-even / truncate select, carry renormalisation
// and exponent overflow saturation to infinity.
module fp_round_core
    import fp_add_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W+2:0] i_mant,
    input  logic              i_round_en,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_ovf,
    output logic              o_inexact
);

    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_all_ones(EXP_W));

    function automatic logic rne_inc(input logic rne, input logic g, input logic r,
                                     input logic s, input logic lsb);
        return rne & g & (r | s | lsb);
    endfunction

    // Overflow when the rounded exponent reaches the reserved code, or the operand already carried it.
    function automatic logic exp_sat(input logic [EXP_W:0] exp_ext, input logic [EXP_W-1:0] exp_in);
        return (exp_ext >= {1'b0, EXP_ONES}) || (exp_in == EXP_ONES);
    endfunction

    logic [MANT_W-1:0] w_m;
    logic              w_g;
    logic              w_r;
    logic              w_s;
    logic              w_rne;
    logic              w_inc;
    logic [MANT_W:0]   w_sum;
    logic              w_carry;
    logic [EXP_W:0]    w_exp_ext;
    logic [MANT_W-1:0] w_mant_rn;

    assign w_m       = i_mant[MANT_W+2:3];
    assign w_g       = i_mant[2];
    assign w_r       = i_mant[1];
    assign w_s       = i_mant[0];
    assign w_rne     = (round_mode_t'(i_round_en) == ROUND_RNE);
    assign w_inc     = rne_inc(w_rne, w_g, w_r, w_s, w_m[0]);
    assign w_sum     = {1'b0, w_m} + (MANT_W+1)'(w_inc);
    assign w_carry   = w_sum[MANT_W];
    assign w_exp_ext = {1'b0, i_exp} + (EXP_W+1)'(w_carry);
    assign w_mant_rn = w_carry ? w_sum[MANT_W:1] : w_sum[MANT_W-1:0];

    assign o_ovf     = exp_sat(w_exp_ext, i_exp);
    assign o_exp     = o_ovf ? EXP_ONES : w_exp_ext[EXP_W-1:0];
    assign o_mant    = o_ovf ? '0 : w_mant_rn;
    assign o_inexact = w_g | w_r | w_s;

endmodule

// File: rtl/fp_round_stage.sv
// Rounding stage with registered output and 2-entry skid buffer: one combinational
// rounding level feeds a main output register backed by a single skid register.
module fp_round_stage
    import fp_add_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic              clk,
    input  logic              res,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W+2:0] in_mant,
    input  logic              in_round_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_ovf,
    output logic              out_inexact
);

    localparam int RES_W = EXP_W + MANT_W + 3;

    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic              r_in_ready;
    logic [RES_W-1:0]  r_main_p1;
    logic [RES_W-1:0]  r_skid_p1;

    logic              w_accept;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_skid_to_main;
    logic [EXP_W-1:0]  w_exp_p0;
    logic [MANT_W-1:0] w_mant_p0;
    logic              w_ovf_p0;
    logic              w_inexact_p0;
    logic [RES_W-1:0]  w_res_p0;

    // Stage p0: combinational rounding of the incoming operand
    fp_round_core #(
        .MANT_W(MANT_W),
        .EXP_W (EXP_W)
    ) u_core (
        .i_exp     (in_exp),
        .i_mant    (in_mant),
        .i_round_en(in_round_en),
        .o_exp     (w_exp_p0),
        .o_mant    (w_mant_p0),
        .o_ovf     (w_ovf_p0),
        .o_inexact (w_inexact_p0)
    );

    assign w_res_p0 = {w_ovf_p0, w_inexact_p0, in_sign, w_exp_p0, w_mant_p0};
    assign w_accept = in_valid & r_in_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_load_main = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && out_ready) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = FULL;
                    w_load_skid = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    w_state_nxt    = ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Stage p1: main/skid registers; in_ready registered from the next state to cut the out_ready path
    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
            r_main_p1  <= '0;
            r_skid_p1  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
            if (w_load_main) begin
                r_main_p1 <= w_res_p0;
            end else if (w_skid_to_main) begin
                r_main_p1 <= r_skid_p1;
            end
            if (w_load_skid) begin
                r_skid_p1 <= w_res_p0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign {out_ovf, out_inexact, out_sign, out_exp, out_mant} = r_main_p1;

endmodule

// File: tb/tb_fp_round_stage.sv
// Directed bench for fp_round_stage (MANT_W = EXP_W = 8): rounding cases,
// overflow, streaming, back-pressure ordering and reset mid-stream.
module tb_fp_round_stage;

    logic        clk = 1'b0;
    logic        res;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [10:0] in_mant;
    logic        in_round_en;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [7:0]  out_mant;
    logic        out_ovf;
    logic        out_inexact;

    int n_tests = 0;
    int n_fail  = 0;

    // observed vector layout: {valid, sign, ovf, inexact, exp[7:0], mant[7:0]}
    logic [19:0] obs;
    assign obs = {out_valid, out_sign, out_ovf, out_inexact, out_exp, out_mant};

    always #5 clk = ~clk;

    fp_round_stage #(.MANT_W(8), .EXP_W(8)) dut (
        .clk        (clk),
        .res        (res),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_round_en(in_round_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_ovf    (out_ovf),
        .out_inexact(out_inexact)
    );

    task automatic set_in(input logic sg, input logic [7:0] e, input logic [7:0] m,
                          input logic [2:0] grs, input logic rnd);
        in_sign     = sg;
        in_exp      = e;
        in_mant     = {m, grs};
        in_round_en = rnd;
        in_valid    = 1'b1;
    endtask

    // Presents one operand for a single edge; returns at the falling edge after acceptance.
    task automatic send(input logic sg, input logic [7:0] e, input logic [7:0] m,
                        input logic [2:0] grs, input logic rnd);
        @(negedge clk);
        set_in(sg, e, m, grs, rnd);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        res = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_in(1'b1, 8'hAA, 8'h55, 3'b111, 1'b1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== 20'h0_0000) begin
            n_fail++; $display("FAIL reset_outputs got %h want %h", obs, 20'h0_0000);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        res = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_ready got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_round_tie_odd;
        send(1'b0, 8'h10, 8'hB3, 3'b100, 1'b1);
        n_tests++;
        if (obs !== {4'b1001, 8'h10, 8'hB4}) begin
            n_fail++; $display("FAIL tie_odd got %h want %h", obs, {4'b1001, 8'h10, 8'hB4});
        end
    endtask

    task automatic test_round_even_trunc;
        send(1'b0, 8'h30, 8'hB2, 3'b100, 1'b1);
        n_tests++;
        if (obs !== {4'b1001, 8'h30, 8'hB2}) begin
            n_fail++; $display("FAIL tie_even got %h want %h", obs, {4'b1001, 8'h30, 8'hB2});
        end
        send(1'b1, 8'h40, 8'hFF, 3'b111, 1'b0);
        n_tests++;
        if (obs !== {4'b1101, 8'h40, 8'hFF}) begin
            n_fail++; $display("FAIL truncate got %h want %h", obs, {4'b1101, 8'h40, 8'hFF});
        end
        send(1'b0, 8'h41, 8'h80, 3'b110, 1'b1);
        n_tests++;
        if (obs !== {4'b1001, 8'h41, 8'h81}) begin
            n_fail++; $display("FAIL above_half got %h want %h", obs, {4'b1001, 8'h41, 8'h81});
        end
        send(1'b0, 8'h42, 8'h91, 3'b000, 1'b0);
        n_tests++;
        if (obs !== {4'b1000, 8'h42, 8'h91}) begin
            n_fail++; $display("FAIL exact_trunc got %h want %h", obs, {4'b1000, 8'h42, 8'h91});
        end
        send(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        n_tests++;
        if (obs !== {4'b1000, 8'h00, 8'h00}) begin
            n_fail++; $display("FAIL zero_pass got %h want %h", obs, {4'b1000, 8'h00, 8'h00});
        end
    endtask

    task automatic test_carry;
        send(1'b0, 8'h20, 8'hFF, 3'b110, 1'b1);
        n_tests++;
        if (obs !== {4'b1001, 8'h21, 8'h80}) begin
            n_fail++; $display("FAIL carry_renorm got %h want %h", obs, {4'b1001, 8'h21, 8'h80});
        end
    endtask

    task automatic test_overflow;
        send(1'b1, 8'hFE, 8'hFF, 3'b100, 1'b1);
        n_tests++;
        if (obs !== {4'b1111, 8'hFF, 8'h00}) begin
            n_fail++; $display("FAIL ovf_carry got %h want %h", obs, {4'b1111, 8'hFF, 8'h00});
        end
        send(1'b0, 8'hFF, 8'h90, 3'b000, 1'b1);
        n_tests++;
        if (obs !== {4'b1010, 8'hFF, 8'h00}) begin
            n_fail++; $display("FAIL ovf_input got %h want %h", obs, {4'b1010, 8'hFF, 8'h00});
        end
        send(1'b0, 8'hFE, 8'h90, 3'b000, 1'b1);
        n_tests++;
        if (obs !== {4'b1000, 8'hFE, 8'h90}) begin
            n_fail++; $display("FAIL no_ovf_max got %h want %h", obs, {4'b1000, 8'hFE, 8'h90});
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_in(1'b0, 8'h50, 8'h11, 3'b000, 1'b0);
        @(negedge clk);
        set_in(1'b1, 8'h51, 8'h23, 3'b100, 1'b1);
        n_tests++;
        if (obs !== {4'b1000, 8'h50, 8'h11} || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first got %h rdy=%b want %h rdy=1", obs, in_ready, {4'b1000, 8'h50, 8'h11});
        end
        @(negedge clk);
        set_in(1'b0, 8'h52, 8'h40, 3'b010, 1'b1);
        n_tests++;
        if (obs !== {4'b1101, 8'h51, 8'h24} || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second got %h rdy=%b want %h rdy=1", obs, in_ready, {4'b1101, 8'h51, 8'h24});
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (obs !== {4'b1001, 8'h52, 8'h40}) begin
            n_fail++; $display("FAIL b2b_third got %h want %h", obs, {4'b1001, 8'h52, 8'h40});
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain got vld=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0;
        set_in(1'b0, 8'h01, 8'h11, 3'b000, 1'b1);
        @(negedge clk);
        set_in(1'b0, 8'h02, 8'h22, 3'b000, 1'b1);
        @(negedge clk);
        n_tests++;
        if (obs !== {4'b1000, 8'h01, 8'h11} || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_full got %h rdy=%b want %h rdy=0", obs, in_ready, {4'b1000, 8'h01, 8'h11});
        end
        set_in(1'b0, 8'h03, 8'h33, 3'b100, 1'b1);
        @(negedge clk);
        n_tests++;
        if (obs !== {4'b1000, 8'h01, 8'h11} || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold got %h rdy=%b want %h rdy=0", obs, in_ready, {4'b1000, 8'h01, 8'h11});
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs !== {4'b1000, 8'h02, 8'h22} || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_out_b got %h rdy=%b want %h rdy=1", obs, in_ready, {4'b1000, 8'h02, 8'h22});
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (obs !== {4'b1001, 8'h03, 8'h34}) begin
            n_fail++; $display("FAIL bp_out_c got %h want %h", obs, {4'b1001, 8'h03, 8'h34});
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_dup got vld=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        out_ready = 1'b0;
        set_in(1'b0, 8'h0A, 8'hAA, 3'b000, 1'b0);
        @(negedge clk);
        set_in(1'b0, 8'h0B, 8'hBB, 3'b000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_full got rdy=%b vld=%b want rdy=0 vld=1", in_ready, out_valid);
        end
        res = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs !== 20'h0_0000 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got %h rdy=%b want %h rdy=0", obs, in_ready, 20'h0_0000);
        end
        res = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_ready got rdy=%b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_discard cycle %0d got vld=%b want 0", i, out_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        res = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_sign = 1'b0;
        in_exp = '0;
        in_mant = '0;
        in_round_en = 1'b0;
        test_reset();
        test_round_tie_odd();
        test_round_even_trunc();
        test_carry();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
